matrix_drain_ctrl: RTL and testbench
====================================

# matrix_drain_ctrl

Sequencer that drains an N×N result matrix from the multiplier's result RAM to a downstream sink (file writer / output port). On a start pulse it walks (row, col) in row-major order, issues one read per element to the synchronous RAM, buffers returned words in a 2-entry skid FIFO, and presents them on a stb/ack stream tagged with their coordinates. It sits between the multiplier core's result storage and the output writer, and signals completion with a one-cycle done pulse.

## Interface
- N, default 8: matrix dimension (≥1).
- DW, default 32: element width.
- AW, default max(1, $clog2(N)): row/col index width.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin drain; sampled only in IDLE.
- busy  out  1  high from first cycle after accepted start until done cycle inclusive.
- done  out  1  one-cycle pulse after last element accepted.
- rd_en  out  1  result RAM read strobe.
- rd_row, rd_col  out  AW each  read address.
- rd_data  in  DW  RAM data, valid exactly one cycle after rd_en.
- out_stb  out  1  output element valid.
- out_ack  in  1  sink accepts element when out_stb && out_ack.
- out_data  out  DW  element value.
- out_row, out_col  out  AW each  element coordinates.
- out_last  out  1  high with element (N-1, N-1).

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: start=1 → RUN; read pointer (r,c) cleared to (0,0). start in any other state ignored.
- RUN: rd_en=1 when credit available: occ + inflight − pop ≤ 1, where occ = FIFO entries (0..2), inflight = rd_en of previous cycle, pop = out_stb && out_ack. rd_row/rd_col = (r,c). On issue: c wraps N-1→0 with r+1; issuing (N-1,N-1) → FLUSH.
- FLUSH: no reads; wait until occ=0, inflight=0 → DONE.
- DONE: done=1 for one cycle → IDLE.
- Read data pushed into FIFO with its (row,col) tag one cycle after rd_en; credit rule guarantees FIFO never overflows.
- out_stb = occ≠0; out_data/out_row/out_col/out_last from FIFO head; must stay stable while out_stb && !out_ack.
- Ordering strictly row-major; every element delivered exactly once.
- Reset: all state cleared to IDLE; FIFO emptied; pending RAM read discarded.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_row=rd_col=0, out_stb=0, out_data=0, out_row=out_col=0, out_last=0.
- Cycle 0 start sampled; cycle 1 rd_en for (0,0); cycle 2 rd_data captured; cycle 3 out_stb=1 (latency 3).
- out_ack held high: one element per cycle sustained; done asserted cycle after last ack.
- Backpressure: out_ack low for k cycles stalls reads after ≤2 buffered + 0 in flight; no data loss.
- N=1: single read, out_last on first element, FLUSH reached immediately after cycle 1.
- Push and pop in same cycle with occ=2: legal, occ stays 2.
- rst_n low in any state: outputs at reset values next cycle; in-progress drain abandoned, no done.

## Structure
- Package matrix_drain_pkg: state encoding constants (IDLE=2'b00, RUN=2'b01, FLUSH=2'b10, DONE=2'b11), index-width helper function.
- Sub-module drain_skid_fifo: 2-entry FIFO, width DW+2·AW+1, push/pop/occ, synchronous active-low reset; controller holds FSM, pointers, credit logic.

## Test plan
- N=4, out_ack=1, RAM word = row·16+col: 16 elements 0x00..0x33 in row-major order, out_last only on 0x33, done pulse one cycle after last ack, latency 3.
- N=4, out_ack random 50%: identical sequence, out_data stable while stalled, FIFO occ never >2.
- out_ack=0 for 20 cycles after start: exactly 2 reads issued, then rd_en=0 until ack resumes; no duplicates or gaps.
- N=1: one read of (0,0), out_last=1 with it, done follows ack.
- rst_n low mid-drain at element 5 then start again: outputs reset next cycle, no done, restart delivers from (0,0).
- start pulsed while busy: ignored; exactly N² elements and one done.

Source files
------------

// File: rtl/matrix_drain_pkg.sv
// Shared definitions for the result-matrix drain sequencer.
package matrix_drain_pkg;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10,
        ST_DONE  = 2'b11
    } drain_state_t;

    // Row/column index width: ceil(log2(n)), never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/drain_skid_fifo.sv
// Two-entry FIFO that absorbs RAM read data while the sink stalls.
// The producer must never push into a full FIFO unless it pops in the same cycle.
module drain_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       occ_reg;
    logic [1:0]       occ_next;
    logic             pop_ok;
    logic [1:0][W-1:0] entry_q;

    // A pop on an empty FIFO is ignored so the pointers cannot desynchronise.
    assign pop_ok = pop && (occ_reg != 2'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [W-1:0] entry_reg;

            // Storage slot: written when the write pointer selects it.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    // Occupancy after this cycle's push/pop; push+pop when full keeps it at 2.
    always_comb begin
        occ_next = occ_reg + 2'(push) - 2'(pop_ok);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop_ok) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            occ_reg <= occ_next;
        end
    end

    assign occ  = occ_reg;
    assign head = entry_q[rd_ptr_reg];

endmodule

// File: rtl/matrix_drain_ctrl.sv
// Drains an N x N result matrix from a synchronous RAM to a stb/ack stream
// in row-major order, tagging every element with its coordinates.
module matrix_drain_ctrl
    import matrix_drain_pkg::*;
#(
    parameter int N  = 8,
    parameter int DW = 32,
    parameter int AW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_row,
    output logic [AW-1:0] rd_col,
    input  logic [DW-1:0] rd_data,
    output logic          out_stb,
    input  logic          out_ack,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_row,
    output logic [AW-1:0] out_col,
    output logic          out_last
);

    localparam int            FW       = DW + 2 * AW + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    drain_state_t    state_reg, state_next;
    logic [AW-1:0]   row_reg, row_next;
    logic [AW-1:0]   col_reg, col_next;
    logic            inflight_reg;
    logic [2*AW:0]   tag_reg;      // {last, row, col} of the read in flight
    logic [1:0]      occ;
    logic [FW-1:0]   head;
    logic            pop;
    logic            credit_ok;
    logic            at_last;

    assign out_stb = (occ != 2'd0);
    assign pop     = out_stb && out_ack;
    assign at_last = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);

    // A new read may issue only if the FIFO can hold it next cycle:
    // occ + inflight - pop <= 1.
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight_reg}) <= (3'd1 + {2'b00, pop});

    // Next-state, read pointer walk and strobes.
    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        rd_en      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    row_next   = '0;
                    col_next   = '0;
                end
            end
            ST_RUN: begin
                if (credit_ok) begin
                    rd_en = 1'b1;
                    if (at_last) begin
                        state_next = ST_FLUSH;
                        row_next   = '0;
                        col_next   = '0;
                    end else if (col_reg == LAST_IDX) begin
                        col_next = '0;
                        row_next = row_reg + AW'(1);
                    end else begin
                        col_next = col_reg + AW'(1);
                    end
                end
            end
            ST_FLUSH: begin
                // Leave as soon as the FIFO will be empty after this edge, so
                // done lands in the cycle right after the final acceptance.
                if (!inflight_reg && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, pointer and in-flight read tracking; reset drops any pending read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            row_reg      <= '0;
            col_reg      <= '0;
            inflight_reg <= 1'b0;
            tag_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            inflight_reg <= rd_en;
            if (rd_en) begin
                tag_reg <= {at_last, row_reg, col_reg};
            end
        end
    end

    drain_skid_fifo #(
        .W (FW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_reg),
        .push_data ({tag_reg, rd_data}),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    assign busy     = (state_reg != ST_IDLE);
    assign rd_row   = row_reg;
    assign rd_col   = col_reg;
    assign out_data = head[DW-1:0];
    assign out_col  = head[DW +: AW];
    assign out_row  = head[DW + AW +: AW];
    assign out_last = head[FW-1];

endmodule

// File: tb/tb_matrix_drain_ctrl.sv
`timescale 1ns/1ps
module tb_matrix_drain_ctrl;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] row;
        logic [AW-1:0] col;
        logic          last;
    } elem_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (N=4)
    logic          rst_n, start, busy, done, rd_en;
    logic [AW-1:0] rd_row, rd_col, out_row, out_col;
    logic [DW-1:0] rd_data, out_data;
    logic          out_stb, out_ack, out_last;

    // Single-element instance (N=1)
    logic          start1, busy1, done1, rd_en1;
    logic [0:0]    rd_row1, rd_col1, out_row1, out_col1;
    logic [DW-1:0] rd_data1, out_data1;
    logic          out_stb1, out_ack1, out_last1;

    matrix_drain_ctrl #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .out_stb(out_stb), .out_ack(out_ack), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    matrix_drain_ctrl #(.N(1), .DW(DW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_row(rd_row1), .rd_col(rd_col1), .rd_data(rd_data1),
        .out_stb(out_stb1), .out_ack(out_ack1), .out_data(out_data1),
        .out_row(out_row1), .out_col(out_col1), .out_last(out_last1)
    );

    // Result RAM models: data valid exactly one cycle after rd_en, junk otherwise.
    logic [DW-1:0] ram [N*N];
    logic [DW-1:0] ram1_word;
    always @(posedge clk) begin
        rd_data  <= rd_en  ? ram[int'(rd_row) * N + int'(rd_col)] : $urandom;
        rd_data1 <= rd_en1 ? ram1_word : $urandom;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Scoreboard and monitor state
    elem_t       exp_q[$];
    int          start_cyc     = 0;
    bit          first_pending = 0;
    bit          last_ack_prev = 0;
    bit          stall_prev    = 0;
    logic [36:0] held          = '0;
    int          outstanding   = 0;
    int          done_cnt      = 0;
    int          rd_cnt        = 0;
    int          acc_cnt       = 0;
    int          ack_mode      = 0;

    // Monitor: compares every accepted element against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_ack_prev = 0;
            stall_prev    = 0;
            outstanding   = 0;
        end else begin
            elem_t e;
            if (done || last_ack_prev) check("done_timing", done, last_ack_prev);
            if (done) done_cnt++;
            last_ack_prev = 0;
            if (rd_en || out_stb) check("outstanding_le2", outstanding <= 2, 1);
            if (rd_en) begin
                outstanding++;
                rd_cnt++;
            end
            if (stall_prev) begin
                check("stb_hold", out_stb, 1);
                check("data_hold", {out_data, out_row, out_col, out_last}, held);
            end
            if (first_pending && (cyc - start_cyc == 1)) check("busy_after_start", busy, 1);
            if (out_stb && first_pending) begin
                check("latency", cyc - start_cyc, 3);
                first_pending = 0;
            end
            if (out_stb && out_ack) begin
                check("queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_row",  out_row,  e.row);
                    check("out_col",  out_col,  e.col);
                    check("out_last", out_last, e.last);
                    $display("elem r=%0d c=%0d data=0x%08h last=%0b", out_row, out_col, out_data, out_last);
                    if (e.last) last_ack_prev = 1;
                end
                outstanding--;
                acc_cnt++;
            end
            stall_prev = out_stb && !out_ack;
            held       = {out_data, out_row, out_col, out_last};
        end
    end

    // Sink acceptance pattern
    initial begin
        out_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       out_ack = 1'b1;
                1:       out_ack = 1'($urandom_range(0, 1));
                default: out_ack = (cyc - start_cyc >= 20);
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ram(input bit pattern);
        for (int i = 0; i < N * N; i++)
            ram[i] = pattern ? DW'((i / N) * 16 + (i % N)) : $urandom;
    endtask

    // Reference model: row-major walk over the RAM contents.
    task automatic issue_start();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                elem_t e;
                e.data = ram[r * N + c];
                e.row  = AW'(r);
                e.col  = AW'(c);
                e.last = (r == N - 1) && (c == N - 1);
                exp_q.push_back(e);
            end
        end
        done_cnt      = 0;
        rd_cnt        = 0;
        acc_cnt       = 0;
        start         = 1'b1;
        start_cyc     = cyc;
        first_pending = 1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (done_cnt == 0 && t < 2000) begin
            tick();
            t++;
        end
        check({name, "_done_seen"}, done_cnt != 0, 1);
        repeat (3) tick();
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_all_delivered"}, exp_q.size(), 0);
        check({name, "_elem_count"}, acc_cnt, N * N);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_rd_en"}, rd_en, 0);
        check({name, "_rd_addr"}, {rd_row, rd_col}, 0);
        check({name, "_out_stb"}, out_stb, 0);
        check({name, "_out_fields"}, {out_data, out_row, out_col, out_last}, 0);
    endtask

    initial begin
        int t;
        int rd1, acc1, ack_cyc, done_cyc, c0;

        rst_n     = 1'b0;
        start     = 1'b0;
        start1    = 1'b0;
        out_ack1  = 1'b0;
        ram1_word = '0;
        repeat (3) tick();
        check_reset_outputs("por");
        rst_n = 1'b1;
        tick();

        // Full-rate drain with an address-derived pattern
        ack_mode = 0;
        fill_ram(1);
        issue_start();
        wait_done("fullrate");

        // Random backpressure with random data
        ack_mode = 1;
        for (int k = 0; k < 3; k++) begin
            fill_ram(0);
            issue_start();
            wait_done("randack");
        end

        // Sink stalled for 20 cycles after start
        ack_mode = 2;
        fill_ram(0);
        issue_start();
        repeat (18) tick();
        check("stall_reads", rd_cnt, 2);
        wait_done("stall");

        // start pulses during a drain must be ignored
        ack_mode = 1;
        fill_ram(0);
        issue_start();
        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(2, 8)) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_done("restart_ignored");

        // Reset mid-drain after five elements, then a clean restart
        ack_mode = 0;
        fill_ram(0);
        issue_start();
        t = 0;
        while (acc_cnt < 5 && t < 200) begin
            tick();
            t++;
        end
        check("midreset_reached5", acc_cnt, 5);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midreset");
        exp_q.delete();
        first_pending = 0;
        done_cnt      = 0;
        rst_n         = 1'b1;
        repeat (6) tick();
        check("midreset_no_done", done_cnt, 0);
        fill_ram(0);
        issue_start();
        wait_done("after_reset");

        // N=1: one read, last flag on the only element, done after its ack
        ram1_word = $urandom;
        out_ack1  = 1'b1;
        rd1 = 0; acc1 = 0; ack_cyc = -10; done_cyc = -20;
        start1 = 1'b1;
        c0     = cyc;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rd_en1) begin
                rd1++;
                check("n1_rd_addr", {rd_row1, rd_col1}, 0);
                check("n1_rd_cycle", cyc - c0, 1);
            end
            if (out_stb1 && out_ack1) begin
                acc1++;
                ack_cyc = cyc;
                check("n1_data", out_data1, ram1_word);
                check("n1_coords", {out_row1, out_col1}, 0);
                check("n1_last", out_last1, 1);
                check("n1_latency", cyc - c0, 3);
                $display("elem1 r=0 c=0 data=0x%08h last=%0b", out_data1, out_last1);
            end
            if (done1) begin
                done_cyc = cyc;
                check("n1_busy_with_done", busy1, 1);
            end
        end
        tick();
        check("n1_reads", rd1, 1);
        check("n1_elems", acc1, 1);
        check("n1_done_timing", done_cyc - ack_cyc, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
